mouse_reader: RTL and testbench

MOUSE_READER -- requirements
Module: mouse_reader

---
 rtl/mouse_reader.sv | 121 ++++++++++++
 tb/tb_mouse_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mouse_reader.sv
// Polls a nibble-serial mouse by toggling rts and sampling d once per edge.
// Define MOUSE_READER_ACCUM_EN to accumulate the raw deltas into xaxis/yaxis.
module mouse_reader #(
   parameter int SETTLE = 16,
   parameter int GAP    = 1600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce1M0,
   input  logic       start,
   output logic       rts,
   input  logic [3:0] d,
   output logic       busy,
   output logic       valid,
   output logic [7:0] dx,
   output logic [7:0] dy,
   output logic [7:0] xaxis,
   output logic [7:0] yaxis
);

   localparam int GW = $clog2(GAP + 1);
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [GW-1:0] GAP_MAX     = GW'(GAP);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SETTLE, ST_DONE} state_t;

   state_t        state;
   logic [GW-1:0] gap_cnt;
   logic [SW-1:0] settle_cnt;
   logic [1:0]    idx;
   logic [15:0]   nib;
   logic          toggle;

   // Every rts edge, whether it opens a frame or advances the index.
   assign toggle = ce1M0 &&
                   ((state == ST_PEND && gap_cnt == GAP_MAX) ||
                    (state == ST_SETTLE && settle_cnt == SETTLE_LAST && idx != 2'd3));

   always_ff @(posedge clock) begin
      if (reset)
         gap_cnt <= '0;
      else if (toggle)
         gap_cnt <= '0;
      else if (ce1M0 && gap_cnt != GAP_MAX)
         gap_cnt <= gap_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         rts        <= 1'b0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         dx         <= '0;
         dy         <= '0;
         idx        <= '0;
         nib        <= '0;
         settle_cnt <= '0;
`ifdef MOUSE_READER_ACCUM_EN
         xaxis      <= '0;
         yaxis      <= '0;
`endif
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A start coinciding with the valid pulse is dropped.
               if (start && !valid) begin
                  state <= ST_PEND;
                  busy  <= 1'b1;
               end
            end
            ST_PEND: begin
               if (toggle) begin
                  rts        <= ~rts;
                  idx        <= '0;
                  settle_cnt <= '0;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (ce1M0) begin
                  if (settle_cnt == SETTLE_LAST) begin
                     // Nibble 0 lands in the top of nib, nibble 3 in the bottom.
                     nib[{~idx, 2'b00} +: 4] <= d;
                     settle_cnt              <= '0;
                     if (idx == 2'd3) begin
                        state <= ST_DONE;
                     end else begin
                        rts <= ~rts;
                        idx <= idx + 2'd1;
                     end
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               dx    <= nib[15:8];
               dy    <= nib[7:0];
               valid <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
`ifdef MOUSE_READER_ACCUM_EN
               // Device convention: X = old - new, Y = new - old.
               xaxis <= xaxis - nib[15:8];
               yaxis <= yaxis + nib[7:0];
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifndef MOUSE_READER_ACCUM_EN
   assign xaxis = 8'h00;
   assign yaxis = 8'h00;
`endif

endmodule

// File: tb/tb_mouse_reader.sv
// Self-checking bench for mouse_reader: device model plus frame-level reference
// (edge timing from the gap/settle rules, bytes and accumulators from the nibbles).
module tb_mouse_reader;

   localparam int SETTLE = 16;
   localparam int GAP    = 1600;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ce1M0 = 1'b0;
   logic       start = 1'b0;
   logic       rts;
   logic [3:0] d = 4'h0;
   logic       busy, valid;
   logic [7:0] dx, dy, xaxis, yaxis;

   int checks   = 0;
   int failures = 0;

   int tick_cnt       = 0;
   int last_edge_tick = 0;
   int edges[$];
   int valid_cnt      = 0;

   logic [15:0] dev_nib  = 16'h0000;
   int          dev_idx  = 0;
   int          dev_last = -100000;
   logic        rts_prev = 1'b0;

   logic [7:0] xacc = 8'h00;
   logic [7:0] yacc = 8'h00;

   mouse_reader #(.SETTLE(SETTLE), .GAP(GAP)) dut (
      .clock (clock),
      .reset (reset),
      .ce1M0 (ce1M0),
      .start (start),
      .rts   (rts),
      .d     (d),
      .busy  (busy),
      .valid (valid),
      .dx    (dx),
      .dy    (dy),
      .xaxis (xaxis),
      .yaxis (yaxis)
   );

   always #5 clock = ~clock;

   // 1 MHz enable: high every other clock.
   always @(posedge clock) begin
      #2;
      ce1M0 = ~ce1M0;
   end

   always @(posedge clock) begin
      if (ce1M0) tick_cnt = tick_cnt + 1;
   end

   // Mouse model: each rts edge advances the nibble index; 1500 quiet ticks reset it.
   always @(negedge clock) begin
      if (!$isunknown(rts) && rts !== rts_prev) begin
         rts_prev = rts;
         edges.push_back(tick_cnt);
         last_edge_tick = tick_cnt;
         if (tick_cnt - dev_last >= 1500) dev_idx = 0;
         else dev_idx = (dev_idx + 1) % 4;
         dev_last = tick_cnt;
         d = dev_nib[(3 - dev_idx) * 4 +: 4];
      end
      if (valid === 1'b1) valid_cnt = valid_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int target;
      target = tick_cnt + n;
      while (tick_cnt < target) @(negedge clock);
   endtask

   // Position so the next posedge carries no tick.
   task automatic align();
      @(negedge clock);
      while (ce1M0 !== 1'b0) @(negedge clock);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_rts"},   32'(rts),   32'd0);
      chk({tag, "_busy"},  32'(busy),  32'd0);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_dx"},    32'(dx),    32'd0);
      chk({tag, "_dy"},    32'(dy),    32'd0);
      chk({tag, "_xaxis"}, 32'(xaxis), 32'd0);
      chk({tag, "_yaxis"}, 32'(yaxis), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_state("reset");
      reset = 1'b0;
      last_edge_tick = tick_cnt;
      xacc = 8'h00;
      yacc = 8'h00;
   endtask

   task automatic frame(input logic [15:0] nib, input int delay, input bit poke);
      int s, exp_first, n, budget;
      dev_nib = nib;
      wait_ticks(delay);
      align();
      s = tick_cnt;
      exp_first = (s + 1 > last_edge_tick + GAP + 1) ? s + 1 : last_edge_tick + GAP + 1;
      edges.delete();
      valid_cnt = 0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      if (poke) begin
         wait_ticks(exp_first - s + 30);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      budget = 4 * (GAP + 4 * SETTLE + 100);
      n = 0;
      while (valid !== 1'b1 && n < budget) begin
         @(negedge clock);
         n = n + 1;
      end
      if (valid !== 1'b1) begin
         chk("valid_timeout", 32'd0, 32'd1);
         return;
      end
`ifdef MOUSE_READER_ACCUM_EN
      xacc = xacc - nib[15:8];
      yacc = yacc + nib[7:0];
`endif
      chk("dx", 32'(dx), 32'(nib[15:8]));
      chk("dy", 32'(dy), 32'(nib[7:0]));
      chk("xaxis", 32'(xaxis), 32'(xacc));
      chk("yaxis", 32'(yaxis), 32'(yacc));
      chk("busy_at_valid", 32'(busy), 32'd0);
      chk("edge_count", 32'(edges.size()), 32'd4);
      if (edges.size() == 4) begin
         chk("first_edge_tick", 32'(edges[0]), 32'(exp_first));
         for (int i = 1; i < 4; i++)
            chk("edge_spacing", 32'(edges[i] - edges[i-1]), 32'(SETTLE));
      end
      $display("frame nib=%h start_tick=%0d exp_first_edge=%0d dx=%h dy=%h xaxis=%h yaxis=%h",
               nib, s, exp_first, dx, dy, xaxis, yaxis);
      if (poke) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("valid_one_clock", 32'(valid), 32'd0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clock);
      do_reset();

      // First frame after reset: gap must elapse from reset.
      frame(16'h3AFE, 10, 1'b0);
      // Start inside the gap window, then well after it has saturated.
      frame(16'($urandom), 500, 1'b0);
      frame(16'($urandom), 2000, 1'b1);

      // Starts while busy and during valid must not launch another frame.
      wait_ticks(200);
      chk("no_extra_edges", 32'(edges.size()), 32'd4);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("single_valid", 32'(valid_cnt), 32'd1);

      // Reset between the 2nd and 3rd samples aborts the frame.
      dev_nib = 16'h1234;
      align();
      edges.delete();
      valid_cnt = 0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (edges.size() < 3 && n < 8 * GAP) begin
         @(negedge clock);
         n = n + 1;
      end
      chk("abort_reached_edge3", 32'(edges.size() >= 3), 32'd1);
      wait_ticks(5);
      do_reset();
      $display("abort reset at tick=%0d", tick_cnt);
      wait_ticks(100);
      chk("abort_no_valid", 32'(valid_cnt), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);

      // Accumulation from 0/0, including a wrap below zero.
      frame(16'h0502, 0, 1'b0);
      frame(16'h0502, 1700, 1'b0);
      frame(16'h01FF, 300, 1'b0);
      frame(16'($urandom), int'($urandom_range(0, 1800)), 1'b0);

      wait_ticks(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
